// File: rtl/exu_muldiv_if.sv
// rtl/exu_muldiv_if.sv - request/response handshake bundle for the RV32M mul/div unit
interface exu_muldiv_if #(
  parameter int XLEN   = 32,
  parameter int INFO_W = 14
);
  logic              i_valid;
  logic              o_ready;
  logic [INFO_W-1:0] i_info_bus;
  logic [XLEN-1:0]   i_rs1;
  logic [XLEN-1:0]   i_rs2;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_result;
  logic              o_busy;

  modport master (
    output i_valid, i_info_bus, i_rs1, i_rs2, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_info_bus, i_rs1, i_rs2, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative RV32M multiply/divide unit: XLEN-cycle shift-add
// multiply and restoring divide behind a valid/ready result handshake.
module exu_muldiv #(
  parameter int         XLEN     = 32,
  parameter int         INFO_W   = 14,
  parameter int         TYPE_LSB = 11,
  parameter logic [2:0] MD_TYPE  = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  exu_muldiv_if.slave md
);
  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  opnd_q;
  logic [XLEN-1:0]  result_q;
  logic             valid_q;
  logic             neg_res_q;
  logic             neg_rem_q;

  logic [2:0]       type_f;
  logic             md_sel;
  logic             any_op;
  logic             accept;
  logic             info_unused;
  op_e              op_dec;
  logic             s1;
  logic             s2;
  logic             neg1;
  logic             neg2;
  logic             is_div;
  logic             is_rem;
  logic             div_zero;
  logic             div_ovf;
  logic             special;
  logic [XLEN-1:0]  abs1;
  logic [XLEN-1:0]  abs2;
  logic [XLEN-1:0]  special_res;

  assign type_f      = md.i_info_bus[TYPE_LSB+2:TYPE_LSB];
  assign md_sel      = (type_f == MD_TYPE);
  assign any_op      = |md.i_info_bus[7:0];
  assign accept      = md.i_valid & (state_q == S_IDLE) & md_sel & any_op & ~md.i_flush;
  assign info_unused = ^md.i_info_bus;

  // Lowest-numbered op bit wins when several are set.
  always_comb begin
    op_dec = OP_MUL;
    for (int i = 7; i >= 0; i--) begin
      if (md.i_info_bus[i]) op_dec = op_e'(3'(i));
    end
  end

  always_comb begin
    s1       = op_dec inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2       = op_dec inside {OP_MULH, OP_DIV, OP_REM};
    is_div   = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem   = op_dec inside {OP_REM, OP_REMU};
    neg1     = s1 & md.i_rs1[XLEN-1];
    neg2     = s2 & md.i_rs2[XLEN-1];
    abs1     = neg1 ? (~md.i_rs1 + 1'b1) : md.i_rs1;
    abs2     = neg2 ? (~md.i_rs2 + 1'b1) : md.i_rs2;
    div_zero = is_div & (md.i_rs2 == '0);
    div_ovf  = is_div & s2 & (md.i_rs1 == INT_MIN) & (md.i_rs2 == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = is_rem ? md.i_rs1 : '1;
    else          special_res = is_rem ? '0 : md.i_rs1;
  end

  // One iteration: acc/lo hold product high/low for multiply, remainder/quotient for divide.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   acc_step;
  logic [XLEN-1:0]   lo_step;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (!div_diff[XLEN]) begin
        acc_step = div_diff[XLEN-1:0];
        lo_step  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = div_shift[XLEN-1:0];
        lo_step  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[XLEN:1];
      lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {acc_step, lo_step};
    prod_s = neg_res_q ? (~prod + 1'b1) : prod;
    quo_s  = neg_res_q ? (~lo_step + 1'b1) : lo_step;
    rem_s  = neg_rem_q ? (~acc_step + 1'b1) : acc_step;

    case (op_q)
      OP_MUL:                       final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo_s;
      default:                      final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (md.i_flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op_dec;
            neg_res_q <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            cnt_q     <= '0;
            acc_q     <= '0;
            lo_q      <= is_div ? abs1 : abs2;
            opnd_q    <= is_div ? abs2 : abs1;
            if (special) begin
              state_q  <= S_DONE;
              result_q <= special_res;
              valid_q  <= 1'b1;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          lo_q  <= lo_step;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            cnt_q    <= '0;
            state_q  <= S_DONE;
            result_q <= final_res;
            valid_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (md.i_ready) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          result_q <= '0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.o_ready  = (state_q == S_IDLE);
  assign md.o_busy   = (state_q != S_IDLE);
  assign md.o_valid  = valid_q;
  assign md.o_result = result_q;
endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - scoreboard bench for exu_muldiv
module tb_exu_muldiv;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  exu_muldiv_if #(.XLEN(32), .INFO_W(14)) md_if ();

  exu_muldiv #(
    .XLEN(32), .INFO_W(14), .TYPE_LSB(11), .MD_TYPE(3'b101)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mkinfo(input logic [2:0] t, input logic [7:0] ops);
    return {t, 3'b000, ops};
  endfunction

  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic signed [63:0] p;
    logic        [63:0] u;
    logic signed [31:0] a32;
    logic signed [31:0] b32;
    logic signed [31:0] r32;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    a32 = a;
    b32 = b;
    case (op)
      0: begin p = sa * sb; return p[31:0]; end
      1: begin p = sa * sb; return p[63:32]; end
      2: begin p = sa * ub; return p[63:32]; end
      3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r32 = a32 / b32; return r32;
      end
      5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r32 = a32 % b32; return r32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 4 && b == 0) return 0;
    if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Drive one request, push its expected result, then pop/compare on o_valid.
  task automatic run_op(input string tag, input logic [7:0] ops, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int   lat;
    logic rdy_ok;
    logic stable_ok;
    logic [31:0] held;
    logic [31:0] want;
    md_if.i_valid    = 1'b1;
    md_if.i_info_bus = mkinfo(3'b101, ops);
    md_if.i_rs1      = a;
    md_if.i_rs2      = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    md_if.i_valid = 1'b0;
    lat    = 0;
    rdy_ok = 1'b1;
    while (!md_if.o_valid && lat < 100) begin
      if (md_if.o_ready || !md_if.o_busy) rdy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 0) check_eq({tag, "_busy"}, {63'd0, rdy_ok}, 64'd1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq({tag, "_res"}, {32'd0, md_if.o_result}, {32'd0, want});
    if (hold > 0) begin
      held      = md_if.o_result;
      stable_ok = 1'b1;
      md_if.i_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (md_if.o_result !== held || !md_if.o_valid || md_if.o_ready) stable_ok = 1'b0;
      end
      check_eq({tag, "_hold"}, {63'd0, stable_ok}, 64'd1);
    end
    md_if.i_ready = 1'b1;
    @(posedge clk); #1;
    md_if.i_ready = 1'b0;
    md_if.i_valid = 1'b0;
    check_eq({tag, "_rel"}, {30'd0, md_if.o_valid, md_if.o_ready, md_if.o_result},
             {30'd0, 1'b0, 1'b1, 32'd0});
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic ok;
    ok = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (md_if.o_valid || md_if.o_busy) ok = 1'b0;
    end
    check_eq(tag, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    md_if.i_valid    = 1'b0;
    md_if.i_info_bus = '0;
    md_if.i_rs1      = '0;
    md_if.i_rs2      = '0;
    md_if.i_flush    = 1'b0;
    md_if.i_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", {29'd0, md_if.o_valid, md_if.o_ready, md_if.o_busy, md_if.o_result},
             {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     8'h01, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 32, 0);
    run_op("mulh",    8'h02, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, 0);
    run_op("mulhu",   8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, 0);
    run_op("mulhsu",  8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
    run_op("div",     8'h10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, 0);
    run_op("rem",     8'h40, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, 0);
    run_op("divu",    8'h20, 32'd100,       32'd7,         32'd14,        32, 0);
    run_op("remu",    8'h80, 32'd100,       32'd7,         32'd2,         32, 0);
    run_op("div0",    8'h10, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,  0);
    run_op("remu0",   8'h80, 32'h1234,      32'd0,         32'h1234,      0,  0);
    run_op("divovf",  8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  0);
    run_op("removf",  8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,  0);
    run_op("multi",   8'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 0);
    run_op("bp",      8'h01, 32'd1234,      32'd5678,      32'd7006652,   32, 10);

    for (int i = 0; i < 12; i++) begin
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      op = $urandom_range(0, 7);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), 8'(1 << op), a, b, model(op, a, b),
             model_lat(op, a, b), 0);
    end

    // Flush at iteration 15 kills the op with no response.
    md_if.i_valid    = 1'b1;
    md_if.i_info_bus = mkinfo(3'b101, 8'h10);
    md_if.i_rs1      = 32'd1000;
    md_if.i_rs2      = 32'd3;
    @(posedge clk); #1;
    md_if.i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    md_if.i_flush = 1'b1;
    @(posedge clk); #1;
    md_if.i_flush = 1'b0;
    check_eq("flush", {61'd0, md_if.o_valid, md_if.o_ready, md_if.o_busy}, {61'd0, 3'b010});
    watch_quiet("flush_quiet", 40);

    // Request presented together with flush is not accepted.
    md_if.i_valid = 1'b1;
    md_if.i_flush = 1'b1;
    @(posedge clk); #1;
    md_if.i_valid = 1'b0;
    md_if.i_flush = 1'b0;
    check_eq("flush_req", {63'd0, md_if.o_busy}, 64'd0);

    // Reset at iteration 15.
    md_if.i_valid    = 1'b1;
    md_if.i_info_bus = mkinfo(3'b101, 8'h01);
    @(posedge clk); #1;
    md_if.i_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", {29'd0, md_if.o_valid, md_if.o_ready, md_if.o_busy, md_if.o_result},
             {29'd0, 1'b0, 1'b1, 1'b0, 32'd0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    watch_quiet("rst_quiet", 40);

    // Foreign type and empty op field are ignored.
    md_if.i_valid    = 1'b1;
    md_if.i_info_bus = mkinfo(3'b001, 8'h01);
    watch_quiet("bad_type", 8);
    md_if.i_info_bus = mkinfo(3'b101, 8'h00);
    watch_quiet("no_op", 8);
    md_if.i_valid = 1'b0;

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
